pip_stage_chain: RTL and testbench

PIP_STAGE_CHAIN -- requirements
Module: pip_stage_chain

---
 rtl/pip_stage_chain_pkg.sv | 53 +++++
 rtl/pip_slot.sv | 65 ++++++
 rtl/pip_stage_chain.sv | 67 ++++++
 tb/tb_pip_stage_chain.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pip_stage_chain_pkg.sv
// Shared defaults for the generic pipeline slot chain, plus RISC-V slot payload layouts
// that a CPU wrapper packs into the chain's flat per-slot data words.
package pip_stage_chain_pkg;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_CNT_W      = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } rv_if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } rv_id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } rv_ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } rv_mem_wb_t;

    // Widest RISC-V slot payload; a CPU wrapper sets DATA_W to this value.
    function automatic int rv_slot_w();
        int w;
        w = $bits(rv_if_id_t);
        if ($bits(rv_id_ex_t)  > w) w = $bits(rv_id_ex_t);
        if ($bits(rv_ex_mem_t) > w) w = $bits(rv_ex_mem_t);
        if ($bits(rv_mem_wb_t) > w) w = $bits(rv_mem_wb_t);
        return w;
    endfunction

    localparam int RV_SLOT_W = rv_slot_w();

endpackage

// File: rtl/pip_slot.sv
// One pipeline slot: valid flag, payload register and saturating stall counter.
// Readiness and upstream-valid are resolved by the chain and arrive as inputs.
module pip_slot #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ready_i,
    input  logic              up_i,
    input  logic              flush_i,
    input  logic              cnt_clr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        if (ready_i) begin
            valid_d = up_i;
        end
        // A killed item must not disturb the stored payload either.
        if (ready_i && up_i && !flush_i) begin
            data_d = data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end

        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (valid_q && !ready_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: the payload register is reset as well, since o_data must read zero while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all slots update from the same pre-edge values.
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/pip_stage_chain.sv
// Generic chain of NUM_STAGES pipeline slots with per-slot hold, flush and stall counting.
// The ready chain ripples combinationally from the consumer back to slot 0.
module pip_stage_chain
    import pip_stage_chain_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_STAGES-1:0][DATA_W-1:0]   i_data,
    input  logic [NUM_STAGES-1:0]               hold,
    input  logic [NUM_STAGES-1:0]               flush,
    input  logic                                out_ready,
    output logic [NUM_STAGES-1:0]               o_valid,
    output logic [NUM_STAGES-1:0][DATA_W-1:0]   o_data,
    output logic                                out_valid,
    input  logic                                cnt_clr,
    output logic [NUM_STAGES-1:0][CNT_W-1:0]    stall_cnt
);

    logic [NUM_STAGES:0]   ready;
    logic [NUM_STAGES-1:0] up;

    // A slot can take new content when empty or when its content leaves this cycle;
    // flush deliberately plays no part here.
    always_comb begin
        ready             = '0;
        ready[NUM_STAGES] = out_ready;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            ready[k] = !o_valid[k] || (!hold[k] && ready[k+1]);
        end
    end

    always_comb begin
        up    = '0;
        up[0] = in_valid;
        for (int k = 1; k < NUM_STAGES; k++) begin
            up[k] = o_valid[k-1] && !hold[k-1];
        end
    end

    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_slot
        pip_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .ready_i   (ready[gi]),
            .up_i      (up[gi]),
            .flush_i   (flush[gi]),
            .cnt_clr_i (cnt_clr),
            .data_i    (i_data[gi]),
            .valid_o   (o_valid[gi]),
            .data_o    (o_data[gi]),
            .cnt_o     (stall_cnt[gi])
        );
    end

    assign in_ready  = ready[0];
    assign out_valid = o_valid[NUM_STAGES-1] && !hold[NUM_STAGES-1];

endmodule

// File: tb/tb_pip_stage_chain.sv
// Self-checking bench for pip_stage_chain: directed scenarios plus randomized traffic
// checked against a slot-level behavioural model.
module tb_pip_stage_chain;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0][DW-1:0]   i_data;
    logic [N-1:0]           hold;
    logic [N-1:0]           flush;
    logic                   out_ready;
    logic [N-1:0]           o_valid;
    logic [N-1:0][DW-1:0]   o_data;
    logic                   out_valid;
    logic                   cnt_clr;
    logic [N-1:0][CW-1:0]   stall_cnt;

    logic                   s_in_ready;
    logic [N-1:0]           s_o_valid;
    logic [N-1:0][DW-1:0]   s_o_data;
    logic                   s_out_valid;
    logic [N-1:0][3:0]      s_stall_cnt;

    pip_stage_chain #(.NUM_STAGES(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .i_data(i_data), .hold(hold), .flush(flush), .out_ready(out_ready),
        .o_valid(o_valid), .o_data(o_data), .out_valid(out_valid),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    pip_stage_chain #(.NUM_STAGES(N), .DATA_W(DW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .i_data(i_data), .hold(hold), .flush(flush), .out_ready(out_ready),
        .o_valid(s_o_valid), .o_data(s_o_data), .out_valid(s_out_valid),
        .cnt_clr(cnt_clr), .stall_cnt(s_stall_cnt)
    );

    // Behavioural model: what each slot holds and how long it has been stuck.
    bit          m_v  [N];
    logic [DW-1:0] m_d [N];
    int          m_c  [N];
    int          m_c4 [N];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = 1'b0; m_d[k] = '0; m_c[k] = 0; m_c4[k] = 0;
        end
    endtask

    // Walk back from the consumer: a slot accepts if empty or if its item moves on.
    function automatic logic [N:0] model_ready();
        logic [N:0] r;
        r = '0;
        r[N] = out_ready;
        for (int k = N - 1; k >= 0; k--) r[k] = !m_v[k] || (!hold[k] && r[k+1]);
        return r;
    endfunction

    function automatic logic [N-1:0] model_vvec();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_v[k];
        return v;
    endfunction

    task automatic advance();
        logic [N:0]    rdy;
        bit            nv [N];
        logic [DW-1:0] nd [N];
        int            nc [N];
        int            nc4[N];
        bit            offered;
        rdy = model_ready();
        for (int k = 0; k < N; k++) begin
            offered = (k == 0) ? bit'(in_valid) : (m_v[k-1] && !hold[k-1]);
            nv[k] = m_v[k]; nd[k] = m_d[k]; nc[k] = m_c[k]; nc4[k] = m_c4[k];
            if (rdy[k]) nv[k] = offered;
            if (flush[k]) nv[k] = 1'b0;
            if (rdy[k] && offered && !flush[k]) nd[k] = i_data[k];
            if (cnt_clr) begin
                nc[k] = 0; nc4[k] = 0;
            end else if (m_v[k] && !rdy[k]) begin
                if (nc[k] < 65535) nc[k]++;
                if (nc4[k] < 15) nc4[k]++;
            end
        end
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            m_v[k] = nv[k]; m_d[k] = nd[k]; m_c[k] = nc[k]; m_c4[k] = nc4[k];
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; hold = '0; flush = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        for (int k = 0; k < N; k++) i_data[k] = '0;
    endtask

    task automatic fill(input int n, input bit clr_last);
        for (int c = 0; c < n; c++) begin
            in_valid = 1'b1; hold = '0; flush = '0; out_ready = 1'b1;
            cnt_clr  = clr_last && (c == n - 1);
            for (int k = 0; k < N; k++) i_data[k] = {$urandom, $urandom};
            advance();
        end
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        #2;
        n_total++; if (o_valid !== 4'b0) $display("FAIL reset_o_valid: got %b want 0000", o_valid); else n_pass++;
        n_total++; if (o_data !== '0) $display("FAIL reset_o_data: got %h want 0", o_data); else n_pass++;
        n_total++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL post_reset_out_valid: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; hold = '0; flush = '0; out_ready = 1'b1; cnt_clr = 1'b0;
            for (int k = 0; k < N; k++) i_data[k] = DW'(k + c);
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready); else n_pass++;
            n_total++; if (o_valid[3] !== (c >= 4)) $display("FAIL stream_o_valid3 c=%0d: got %b want %b", c, o_valid[3], c >= 4); else n_pass++;
            if (c >= 4) begin
                n_total++; if (o_data[3] !== DW'(c + 2)) $display("FAIL stream_o_data3 c=%0d: got %0d want %0d", c, o_data[3], c + 2); else n_pass++;
                n_total++; if (out_valid !== 1'b1) $display("FAIL stream_out_valid c=%0d: got %b want 1", c, out_valid); else n_pass++;
            end
            advance();
        end
    endtask

    task automatic test_hold_bubble();
        logic [DW-1:0] snap0, snap1;
        fill(4, 1'b1);
        snap0 = o_data[0]; snap1 = o_data[1];
        for (int h = 0; h < 3; h++) begin
            in_valid = 1'b1; hold = 4'b0010; flush = '0; out_ready = 1'b1;
            for (int k = 0; k < N; k++) i_data[k] = {$urandom, $urandom};
            #1;
            n_total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready h=%0d: got %b want 0", h, in_ready); else n_pass++;
            n_total++; if (o_data[0] !== snap0 || o_data[1] !== snap1) $display("FAIL hold_frozen h=%0d: got %h/%h want %h/%h", h, o_data[0], o_data[1], snap0, snap1); else n_pass++;
            if (h >= 1) begin
                n_total++; if (o_valid[2] !== 1'b0) $display("FAIL hold_bubble h=%0d: got %b want 0", h, o_valid[2]); else n_pass++;
            end
            advance();
        end
        hold = '0;
        #1;
        n_total++; if (stall_cnt[1] !== 16'd3) $display("FAIL hold_stall_cnt1: got %0d want 3", stall_cnt[1]); else n_pass++;
        n_total++; if (stall_cnt[0] !== 16'd3) $display("FAIL hold_stall_cnt0: got %0d want 3", stall_cnt[0]); else n_pass++;
        n_total++; if (o_data[1] !== snap1 || o_valid[1:0] !== 2'b11) $display("FAIL hold_kept: got %h v=%b want %h v=11", o_data[1], o_valid[1:0], snap1); else n_pass++;
    endtask

    task automatic test_backpressure();
        int acc = 0, cons = 0;
        logic [DW-1:0] held, last;
        bit have_last = 1'b0;
        drive_idle();
        flush = '1;
        advance();
        flush = '0;
        for (int c = 0; c < 16; c++) begin
            in_valid  = (c < 8);
            out_ready = !(c == 6 || c == 7);
            for (int k = 0; k < N; k++) i_data[k] = {32'(cyc), 32'(k)};
            #1;
            if (c == 6) held = o_data[3];
            if (c == 6 || c == 7) begin
                n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d: got %b want 0", c, in_ready); else n_pass++;
                n_total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid c=%0d: got %b want 1", c, out_valid); else n_pass++;
                n_total++; if (o_data[3] !== held) $display("FAIL bp_stable c=%0d: got %h want %h", c, o_data[3], held); else n_pass++;
            end
            if (in_valid && in_ready) acc++;
            if (out_valid && out_ready) begin
                if (have_last) begin
                    n_total++; if (o_data[3] === last) $display("FAIL bp_duplicate c=%0d: got %h again, want a new item", c, o_data[3]); else n_pass++;
                end
                last = o_data[3]; have_last = 1'b1;
                cons++;
            end
            advance();
        end
        n_total++; if (cons !== acc) $display("FAIL bp_item_count: got %0d out want %0d in", cons, acc); else n_pass++;
    endtask

    task automatic test_flush();
        logic [DW-1:0] snap0, snap1, d2, d3;
        fill(4, 1'b0);
        snap0 = o_data[0]; snap1 = o_data[1];
        in_valid = 1'b1; flush = 4'b0011; hold = '0; out_ready = 1'b1;
        for (int k = 0; k < N; k++) i_data[k] = {$urandom, $urandom};
        d2 = i_data[2]; d3 = i_data[3];
        advance();
        flush = '0; in_valid = 1'b0;
        #1;
        n_total++; if (o_valid !== 4'b1100) $display("FAIL flush_valid: got %b want 1100", o_valid); else n_pass++;
        n_total++; if (o_data[0] !== snap0 || o_data[1] !== snap1) $display("FAIL flush_data_kept: got %h/%h want %h/%h", o_data[0], o_data[1], snap0, snap1); else n_pass++;
        n_total++; if (o_data[2] !== d2 || o_data[3] !== d3) $display("FAIL flush_advance: got %h/%h want %h/%h", o_data[2], o_data[3], d2, d3); else n_pass++;
        advance();
        #1;
        n_total++; if (o_valid !== 4'b1000) $display("FAIL flush_dropped: got %b want 1000", o_valid); else n_pass++;
    endtask

    task automatic test_saturation();
        fill(4, 1'b1);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; hold = 4'b1000; flush = '0; out_ready = 1'b1;
            advance();
        end
        #1;
        n_total++; if (s_stall_cnt[3] !== 4'd15) $display("FAIL sat_cnt4: got %0d want 15", s_stall_cnt[3]); else n_pass++;
        n_total++; if (stall_cnt[3] !== 16'd20) $display("FAIL sat_cnt16: got %0d want 20", stall_cnt[3]); else n_pass++;
        cnt_clr = 1'b1;
        advance();
        cnt_clr = 1'b0;
        #1;
        n_total++; if (s_stall_cnt[3] !== 4'd0) $display("FAIL sat_clr4: got %0d want 0", s_stall_cnt[3]); else n_pass++;
        n_total++; if (stall_cnt[3] !== 16'd0) $display("FAIL sat_clr16: got %0d want 0", stall_cnt[3]); else n_pass++;
        hold = '0;
    endtask

    task automatic test_reset_mid();
        fill(4, 1'b0);
        in_valid = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_total++; if (o_valid !== 4'b0 || o_data !== '0) $display("FAIL midrst_state: got v=%b d=%h want 0", o_valid, o_data); else n_pass++;
        n_total++; if (stall_cnt !== '0) $display("FAIL midrst_cnt: got %h want 0", stall_cnt); else n_pass++;
        n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_hs: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else n_pass++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); else n_pass++;
        advance();
        #1;
        n_total++; if (o_valid !== 4'b0001) $display("FAIL midrst_first_load: got %b want 0001", o_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [N:0] rdy;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            cnt_clr   = ($urandom_range(31) == 0);
            for (int k = 0; k < N; k++) begin
                hold[k]   = ($urandom_range(3) == 0);
                flush[k]  = ($urandom_range(15) == 0);
                i_data[k] = {$urandom, $urandom};
            end
            #1;
            rdy = model_ready();
            n_total++; if (in_ready !== rdy[0]) $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, rdy[0]); else n_pass++;
            n_total++; if (out_valid !== (m_v[N-1] && !hold[N-1])) $display("FAIL rnd_out_valid c=%0d: got %b want %b", c, out_valid, m_v[N-1] && !hold[N-1]); else n_pass++;
            n_total++; if (o_valid !== model_vvec()) $display("FAIL rnd_o_valid c=%0d: got %b want %b", c, o_valid, model_vvec()); else n_pass++;
            for (int k = 0; k < N; k++) begin
                n_total++; if (o_data[k] !== m_d[k]) $display("FAIL rnd_o_data%0d c=%0d: got %h want %h", k, c, o_data[k], m_d[k]); else n_pass++;
                n_total++; if (stall_cnt[k] !== CW'(m_c[k])) $display("FAIL rnd_cnt%0d c=%0d: got %0d want %0d", k, c, stall_cnt[k], m_c[k]); else n_pass++;
                n_total++; if (s_stall_cnt[k] !== 4'(m_c4[k])) $display("FAIL rnd_cnt4_%0d c=%0d: got %0d want %0d", k, c, s_stall_cnt[k], m_c4[k]); else n_pass++;
            end
            advance();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_hold_bubble();
        test_backpressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
